// File: rtl/snd_pkg.sv
// -----------------------------------------------------------------------------
// snd_pkg
// Shared definitions for the sound arbiter slice:
//   - state_t  : arbiter FSM encoding (IDLE=0, PLAY=1, GAP=2)
//   - snd_id_t : tone select codes driven to the audio generator
//   - CNT_W    : width of the tone/gap duration counter
//   - pick_grant() : fixed-priority selection among pending requests
// -----------------------------------------------------------------------------
package snd_pkg;

    localparam int unsigned CNT_W = 26;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SND_NONE = 2'd0,
        SND_CNT  = 2'd1,
        SND_GOAL = 2'd2,
        SND_FIN  = 2'd3
    } snd_id_t;

    // Finish outranks goal, goal outranks countdown; NONE when nothing waits.
    function automatic snd_id_t pick_grant(input logic       fin_pend,
                                           input logic [1:0] goal_cnt,
                                           input logic       cnt_pend);
        snd_id_t pick;
        if (fin_pend) begin
            pick = SND_FIN;
        end else if (goal_cnt != 2'd0) begin
            pick = SND_GOAL;
        end else if (cnt_pend) begin
            pick = SND_CNT;
        end else begin
            pick = SND_NONE;
        end
        return pick;
    endfunction

endpackage

// File: rtl/snd_timer.sv
// -----------------------------------------------------------------------------
// snd_timer
// Loadable down-counter that times tones and gaps. A load strobe takes
// priority over counting; once at zero the counter holds there.
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-low reset (counter -> 0)
//   load     : load strobe
//   load_val : value loaded on load
//   zero     : high while the counter is 0
// -----------------------------------------------------------------------------
module snd_timer
    import snd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count_r;

    // Duration counter: load, otherwise count down and stick at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (count_r != {CNT_W{1'b0}}) begin
            count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/sound_arbiter.sv
// -----------------------------------------------------------------------------
// sound_arbiter
// Queues goal / countdown / finish sound requests and plays them one at a
// time, separated by a silent gap. Priority fin > goal > cnt. Goal requests
// are counted up to 3; further goal requests while full are dropped and
// reported on 'drop'. Countdown and finish requests are sticky bits.
//
// Configuration macro: SND_PREEMPT_EN
//   defined   : a finish request during a goal/cnt tone aborts that tone and
//               starts the finish tone on the next edge (aborted tone lost).
//   undefined : a finish request during a tone simply queues.
//
// Parameters: DUR_GOAL, DUR_CNT, DUR_FIN (tone lengths), GAP (silence length),
//             all in clk cycles and >= 1.
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-low reset
//   req_goal : one-cycle pulse per goal
//   req_cnt  : one-cycle pulse per countdown second
//   req_fin  : one-cycle pulse at game finish
//   mute     : level, gates snd_en only
//   snd_id   : tone select (0 none, 1 cnt, 2 goal, 3 fin), registered
//   snd_en   : tone enable, registered
//   busy     : high whenever the arbiter is not idle, registered
//   drop     : one-cycle pulse when a goal request is discarded, registered
// -----------------------------------------------------------------------------
module sound_arbiter
    import snd_pkg::*;
#(
    parameter logic [25:0] DUR_GOAL = 26'd25_000_000,
    parameter logic [25:0] DUR_CNT  = 26'd10_000_000,
    parameter logic [25:0] DUR_FIN  = 26'd50_000_000,
    parameter logic [25:0] GAP      = 26'd2_000_000
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       req_goal,
    input  logic       req_cnt,
    input  logic       req_fin,
    input  logic       mute,
    output logic [1:0] snd_id,
    output logic       snd_en,
    output logic       busy,
    output logic       drop
);

    // Counter load values are length-1 because the terminal count itself
    // is one of the cycles spent in the state.
    function automatic logic [CNT_W-1:0] dur_m1(input snd_id_t id);
        logic [CNT_W-1:0] val;
        case (id)
            SND_FIN:  val = DUR_FIN  - 26'd1;
            SND_GOAL: val = DUR_GOAL - 26'd1;
            SND_CNT:  val = DUR_CNT  - 26'd1;
            default:  val = {CNT_W{1'b0}};
        endcase
        return val;
    endfunction

    state_t           state_r, state_s;
    snd_id_t          gnt_r, gnt_s;
    snd_id_t          pick_s;
    snd_id_t          grant_s;
    logic             preempt_s;

    logic [1:0]       goal_cnt_r, goal_cnt_s;
    logic             fin_pend_r, fin_pend_s;
    logic             cnt_pend_r, cnt_pend_s;
    logic             drop_s;

    logic             load_s;
    logic [CNT_W-1:0] load_val_s;
    logic             timer_zero_s;

    snd_id_t          snd_id_r;
    logic             snd_en_r;
    logic             busy_r;
    logic             drop_r;

    snd_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load_s),
        .load_val (load_val_s),
        .zero     (timer_zero_s)
    );

    // Highest-priority pending request, used at IDLE and at end of GAP.
    always_comb begin
        pick_s = pick_grant(fin_pend_r, goal_cnt_r, cnt_pend_r);
    end

    // FSM next state, grant decision and timer load control.
    always_comb begin
        state_s    = state_r;
        gnt_s      = gnt_r;
        grant_s    = SND_NONE;
        preempt_s  = 1'b0;
        load_s     = 1'b0;
        load_val_s = {CNT_W{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (pick_s != SND_NONE) begin
                    state_s    = ST_PLAY;
                    gnt_s      = pick_s;
                    grant_s    = pick_s;
                    load_s     = 1'b1;
                    load_val_s = dur_m1(pick_s);
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PLAY: begin
`ifdef SND_PREEMPT_EN
                // The finish pulse itself is granted here; it never enters
                // the pending bit, and the aborted tone is not re-queued.
                if (req_fin && (gnt_r != SND_FIN)) begin
                    state_s    = ST_PLAY;
                    gnt_s      = SND_FIN;
                    preempt_s  = 1'b1;
                    load_s     = 1'b1;
                    load_val_s = dur_m1(SND_FIN);
                end else if (timer_zero_s) begin
                    state_s    = ST_GAP;
                    load_s     = 1'b1;
                    load_val_s = GAP - 26'd1;
                end else begin
                    state_s = ST_PLAY;
                end
`else
                if (timer_zero_s) begin
                    state_s    = ST_GAP;
                    load_s     = 1'b1;
                    load_val_s = GAP - 26'd1;
                end else begin
                    state_s = ST_PLAY;
                end
`endif
            end
            ST_GAP: begin
                if (timer_zero_s) begin
                    if (pick_s != SND_NONE) begin
                        state_s    = ST_PLAY;
                        gnt_s      = pick_s;
                        grant_s    = pick_s;
                        load_s     = 1'b1;
                        load_val_s = dur_m1(pick_s);
                    end else begin
                        state_s = ST_IDLE;
                        gnt_s   = SND_NONE;
                    end
                end else begin
                    state_s = ST_GAP;
                end
            end
            default: begin
                state_s = ST_IDLE;
                gnt_s   = SND_NONE;
            end
        endcase
    end

    // Pending bookkeeping: a grant consumes one request of its class on the
    // same edge that a new pulse of that class may add one back.
    always_comb begin
        goal_cnt_s = goal_cnt_r;
        drop_s     = 1'b0;
        if (req_goal && (grant_s != SND_GOAL)) begin
            if (goal_cnt_r == 2'd3) begin
                drop_s = 1'b1;
            end else begin
                goal_cnt_s = goal_cnt_r + 2'd1;
            end
        end else if (!req_goal && (grant_s == SND_GOAL)) begin
            goal_cnt_s = goal_cnt_r - 2'd1;
        end else begin
            goal_cnt_s = goal_cnt_r;
        end
        fin_pend_s = (fin_pend_r & (grant_s != SND_FIN) & ~preempt_s)
                   | (req_fin & ~preempt_s);
        cnt_pend_s = (cnt_pend_r & (grant_s != SND_CNT)) | req_cnt;
    end

    // State, grant and pending registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            gnt_r      <= SND_NONE;
            goal_cnt_r <= 2'd0;
            fin_pend_r <= 1'b0;
            cnt_pend_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            gnt_r      <= gnt_s;
            goal_cnt_r <= goal_cnt_s;
            fin_pend_r <= fin_pend_s;
            cnt_pend_r <= cnt_pend_s;
        end
    end

    // Output registers, derived from the current state so inputs never
    // reach outputs combinationally; mute only gates the enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snd_id_r <= SND_NONE;
            snd_en_r <= 1'b0;
            busy_r   <= 1'b0;
            drop_r   <= 1'b0;
        end else begin
            snd_id_r <= (state_r == ST_PLAY) ? gnt_r : SND_NONE;
            snd_en_r <= (state_r == ST_PLAY) & ~mute;
            busy_r   <= (state_r != ST_IDLE);
            drop_r   <= drop_s;
        end
    end

    assign snd_id = snd_id_r;
    assign snd_en = snd_en_r;
    assign busy   = busy_r;
    assign drop   = drop_r;

endmodule

// File: doc/sound_arbiter.md
SOUND_ARBITER -- requirements
Module: sound_arbiter

Interface
REQ-001 Parameter DUR_GOAL, default 26'd25_000_000; goal tone length in clk cycles (>=1).
REQ-002 Parameter DUR_CNT, default 26'd10_000_000; countdown beep length in clk cycles (>=1).
REQ-003 Parameter DUR_FIN, default 26'd50_000_000; finish buzzer length in clk cycles (>=1).
REQ-004 Parameter GAP, default 26'd2_000_000; silent cycles between tones (>=1).
REQ-005 Port clk  input  1  sole clock; all state updates on posedge.
REQ-006 Port rst  input  1  asynchronous, active-low reset.
REQ-007 Port req_goal  input  1  one-cycle pulse per valid goal.
REQ-008 Port req_cnt  input  1  one-cycle pulse per countdown second.
REQ-009 Port req_fin  input  1  one-cycle pulse on game finish.
REQ-010 Port mute  input  1  level; silences output, sequencing continues.
REQ-011 Port snd_id  output  2  tone select to audio generator: 0 none, 1 cnt, 2 goal, 3 fin.
REQ-012 Port snd_en  output  1  tone enable to audio generator.
REQ-013 Port busy  output  1  high whenever state is not IDLE.
REQ-014 Port drop  output  1  one-cycle pulse when a goal request is discarded.

Function
REQ-015 FSM states IDLE, PLAY, GAP; one duration down-counter, 26 bits.
REQ-016 Pending: goal = 2-bit saturating count (0..3); cnt and fin = sticky bits; each set on request pulse.
REQ-017 Goal request while count==3 and no same-cycle goal grant: count stays 3, drop pulses next cycle.
REQ-018 IDLE with any pending: next edge -> PLAY, grant highest priority fin > goal > cnt, counter loads DUR-1 of granted tone.
REQ-019 Grant clears fin/cnt bit or decrements goal count on the same edge; a same-cycle request of that class re-sets it (goal net unchanged).
REQ-020 Latency: request pulse at edge k into empty IDLE -> snd_en high from edge k+2.
REQ-021 PLAY: snd_en = ~mute, snd_id = granted tone; counter decrements each cycle; at 0 -> GAP, counter loads GAP-1.
REQ-022 PLAY lasts exactly DUR cycles of the granted tone; GAP lasts exactly GAP cycles.
REQ-023 GAP: snd_en=0, snd_id=0; at counter 0 -> IDLE if nothing pending, else directly PLAY with new grant per REQ-018.
REQ-024 Requests arriving in PLAY/GAP are queued, never lost except per REQ-017.
REQ-025 mute never alters state, counter or pending; only gates snd_en.
REQ-026 All outputs registered; no combinational path from inputs to outputs.

Reset
REQ-027 rst low: state IDLE, counter 0, all pending cleared, snd_id=0, snd_en=0, busy=0, drop=0, immediately and asynchronously.
REQ-028 Reset mid-PLAY aborts the tone; requests pulsing during reset are discarded.

Configuration
REQ-029 Macro SND_PREEMPT_EN defined: req_fin during PLAY of goal/cnt aborts it next edge, enters PLAY with fin (counter DUR_FIN-1), aborted tone not replayed.
REQ-030 SND_PREEMPT_EN undefined: req_fin queues like any other request per REQ-024.

Structure
REQ-031 Package snd_pkg holds state encoding (IDLE=0, PLAY=1, GAP=2) and snd_id constants (NONE, CNT, GOAL, FIN).
REQ-032 Sub-module snd_timer: loadable 26-bit down-counter with load value, load strobe and zero flag.

Verification (DUR_GOAL=8, DUR_CNT=4, DUR_FIN=12, GAP=2)
REQ-033 Single req_goal at edge 10 -> snd_en/snd_id=2 high edges 12..19, GAP 20..21, busy low from 22.
REQ-034 req_cnt and req_goal same cycle -> goal tone 8 cycles, 2 gap, then cnt tone 4 cycles, then IDLE.
REQ-035 Five req_goal pulses during one cnt tone -> drop pulses twice, exactly 3 goal tones follow.
REQ-036 mute high through a goal tone -> snd_en stays 0, busy and durations identical to REQ-033.
REQ-037 rst low mid-PLAY -> all outputs 0 immediately; after release no tone without new request.
REQ-038 SND_PREEMPT_EN: req_fin at cycle 3 of goal tone -> snd_id=3 next edge for 12 cycles, goal not replayed; undefined: fin plays after goal+gap.
